seq_mul_div: RTL and testbench
==============================

Name: seq_mul_div

Overview:
- Iterative multiply/divide unit that sits beside and downstream of the 32-bit adder in the SPU execute stage.
- Takes two operands and an opcode, runs one shift-add or shift-subtract step per clock, and returns a 2×WIDTH result split into Hi/Lo registers.
- Uses a start/busy/done handshake so the control unit stalls while an operation is in flight.

Parameters:
WIDTH, 32, operand width in bits; Hi and Lo are each WIDTH bits
CNT_W, 6, iteration counter width; must satisfy 2^CNT_W > WIDTH

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous, active-high reset
start  input  1  request; sampled only when busy=0
op  input  2  00 MULU, 01 MULS, 10 DIVU, 11 DIVS
A  input  WIDTH  multiplicand / dividend
B  input  WIDTH  multiplier / divisor
busy  output  1  operation in progress
done  output  1  one-cycle pulse when Hi/Lo/DZ are valid
Hi  output  WIDTH  MUL: product[2W-1:W]; DIV: remainder
Lo  output  WIDTH  MUL: product[W-1:0]; DIV: quotient
DZ  output  1  divide-by-zero flag for the last completed operation

Behaviour:
- Reset (async, any time including mid-operation): state=IDLE; busy=0, done=0, Hi=0, Lo=0, DZ=0; counter=0; in-flight operation discarded.
- States: IDLE, RUN, FIX.
- IDLE: on a clock edge with start=1:
  - latch op, |A|, |B| (absolute values for signed ops, raw values for unsigned), and the result signs;
  - clear the accumulator and counter; go to RUN; busy=1 from the next cycle.
- RUN: one iteration per edge, WIDTH iterations total, counter increments.
  - MUL: LSB-first shift-add into a 2W accumulator.
  - DIV: restoring division, one (W+1)-bit compare/subtract per step, MSB-first quotient.
  - After iteration WIDTH go to FIX.
- FIX: one edge.
  - Apply sign correction: MULS product negated if sign(A)^sign(B); DIVS quotient negated if sign(A)^sign(B); DIVS remainder takes sign of A.
  - Load Hi/Lo/DZ; done=1 for exactly this one cycle; busy=0; return to IDLE.
- Latency: start sampled at edge N → busy high in cycles N+1..N+W+1 → done high in the cycle after edge N+W+1 (W+1 edges; 33 for W=32).
- Start while busy=1: ignored. Operands A/B may change freely after acceptance.
- Start during the done cycle: accepted, because busy=0 then. done drops next cycle and busy rises.
- Hi/Lo/DZ hold their value from the last done until the next done. They do not change during RUN.
- Divide by zero (B=0, DIVU or DIVS):
  - skip RUN; IDLE → FIX directly; done one cycle later (cycle after edge N+1);
  - Lo=all ones, Hi=A (raw, unsigned interpretation), DZ=1.
- DZ=0 for all MUL ops and non-zero-divisor DIV ops.
- DIVS overflow (A=most-negative, B=−1): Lo=most-negative (0x80000000 for W=32), Hi=0, DZ=0; no trap.
- Quotient truncates toward zero. Identities that must hold for all non-zero B: A = Lo·B + Hi, with |Hi| < |B|.
- MULS/MULU results are exact 2W-bit products. No overflow flag is produced.

Test Plan:
- Reset then idle: Hi=Lo=0, busy=done=DZ=0. Assert rst mid-RUN → busy=0 immediately, no done pulse afterwards.
- MULU A=0xFFFFFFFF, B=0xFFFFFFFF → after 33 cycles done=1, Hi=0xFFFFFFFE, Lo=0x00000001. busy high for exactly 33 cycles.
- MULS A=0xFFFFFFFD (−3), B=7 → Hi=0xFFFFFFFF, Lo=0xFFFFFFEB (−21). MULU with the same operands → Hi=0x00000006, Lo=0xFFFFFFEB.
- DIVS A=−7 (0xFFFFFFF9), B=2 → Lo=0xFFFFFFFD (−3), Hi=0xFFFFFFFF (−1). DIVU A=100, B=7 → Lo=14, Hi=2. DIVS A=0x80000000, B=0xFFFFFFFF → Lo=0x80000000, Hi=0.
- DIVU A=0x1234, B=0 → done one cycle after the edge following start, DZ=1, Lo=0xFFFFFFFF, Hi=0x1234. A following MULU 3×4 → DZ=0, Lo=12.
- Handshake: pulse start again while busy → ignored, result unchanged. Assert start during the done cycle with MULU 5×6 → accepted, next done gives Lo=30. Change A/B after acceptance → no effect on the result.

Source files
------------

// File: rtl/seq_mul_div.sv
// seq_mul_div
// Iterative multiply/divide unit for the SPU execute stage. One shift-add
// (multiply) or restoring compare/subtract (divide) step is done per clock.
// The 2*WIDTH result comes back split into Hi and Lo.
//
// Ports
//   clk   : system clock, rising edge
//   rst   : asynchronous reset, active high
//   start : request; sampled only while busy=0
//   op    : 00 MULU, 01 MULS, 10 DIVU, 11 DIVS
//   A, B  : multiplicand/dividend, multiplier/divisor
//   busy  : operation in flight (RUN and FIX)
//   done  : one-cycle pulse when Hi/Lo/DZ carry a new result
//   Hi    : MUL product upper half; DIV remainder
//   Lo    : MUL product lower half; DIV quotient
//   DZ    : divide-by-zero flag of the last completed operation
//
// state | meaning
// IDLE  | waiting for start; Hi/Lo/DZ hold the last result
// RUN   | WIDTH iterations of shift-add or shift-subtract
// FIX   | sign correction, load Hi/Lo/DZ, pulse done

module seq_mul_div #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] Hi,
  output logic [WIDTH-1:0] Lo,
  output logic             DZ
);

  localparam int W2 = 2 * WIDTH;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_FIX  = 2'd2
  } state_t;

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic             r_is_div;
  logic             r_neg_q;   // product / quotient must be negated
  logic             r_neg_r;   // remainder takes the (negative) sign of A
  logic             r_dz;
  logic [WIDTH-1:0] r_b;
  // MUL: {partial product, remaining multiplier bits}
  // DIV: {partial remainder, remaining dividend bits / quotient bits}
  logic [W2-1:0]    r_acc;

  logic             w_signed;
  logic [WIDTH-1:0] w_abs_a;
  logic [WIDTH-1:0] w_abs_b;
  logic             w_last;
  logic [WIDTH:0]   w_add;
  logic [WIDTH:0]   w_shift;
  logic [WIDTH:0]   w_diff;
  logic             w_ge;
  logic [WIDTH-1:0] w_rem_next;
  logic [W2-1:0]    w_step;
  logic [W2-1:0]    w_prod;
  logic [WIDTH-1:0] w_quo;
  logic [WIDTH-1:0] w_rem;
  logic [WIDTH-1:0] w_fix_hi;
  logic [WIDTH-1:0] w_fix_lo;

  assign w_signed = op[0];
  assign w_abs_a  = (w_signed && A[WIDTH-1]) ? (~A + WIDTH'(1)) : A;
  assign w_abs_b  = (w_signed && B[WIDTH-1]) ? (~B + WIDTH'(1)) : B;

  assign w_last = (r_cnt == CNT_W'(WIDTH - 1));

  // Multiply step: add multiplicand when the current LSB is set, then shift
  // the carry-extended sum down into the upper half.
  assign w_add = {1'b0, r_acc[W2-1:WIDTH]} + {1'b0, (r_acc[0] ? r_b : {WIDTH{1'b0}})};

  // Divide step: bring the next dividend bit into the remainder. The
  // remainder is always below the divisor, so WIDTH+1 bits cannot overflow.
  assign w_shift    = {r_acc[W2-1:WIDTH], r_acc[WIDTH-1]};
  assign w_ge       = (w_shift >= {1'b0, r_b});
  assign w_diff     = w_shift - {1'b0, r_b};
  assign w_rem_next = w_ge ? w_diff[WIDTH-1:0] : w_shift[WIDTH-1:0];

  assign w_step = r_is_div ? {w_rem_next, r_acc[WIDTH-2:0], w_ge}
                           : {w_add, r_acc[WIDTH-1:1]};

  assign w_prod = r_neg_q ? (~r_acc + W2'(1)) : r_acc;
  assign w_quo  = r_neg_q ? (~r_acc[WIDTH-1:0] + WIDTH'(1)) : r_acc[WIDTH-1:0];
  assign w_rem  = r_neg_r ? (~r_acc[W2-1:WIDTH] + WIDTH'(1)) : r_acc[W2-1:WIDTH];

  // Divide by zero keeps the raw dividend in the lower half of r_acc.
  always_comb begin
    w_fix_hi = '0;
    w_fix_lo = '0;
    if (r_dz) begin
      w_fix_hi = r_acc[WIDTH-1:0];
      w_fix_lo = '1;
    end else if (r_is_div) begin
      w_fix_hi = w_rem;
      w_fix_lo = w_quo;
    end else begin
      w_fix_hi = w_prod[W2-1:WIDTH];
      w_fix_lo = w_prod[WIDTH-1:0];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      r_is_div <= 1'b0;
      r_neg_q  <= 1'b0;
      r_neg_r  <= 1'b0;
      r_dz     <= 1'b0;
      r_b      <= '0;
      r_acc    <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      Hi       <= '0;
      Lo       <= '0;
      DZ       <= 1'b0;
    end else begin
      done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_is_div <= op[1];
            r_neg_q  <= w_signed & (A[WIDTH-1] ^ B[WIDTH-1]);
            r_neg_r  <= w_signed & A[WIDTH-1];
            r_b      <= w_abs_b;
            r_cnt    <= '0;
            busy     <= 1'b1;
            if (op[1] && (B == '0)) begin
              r_dz    <= 1'b1;
              r_acc   <= {{WIDTH{1'b0}}, A};
              r_state <= S_FIX;
            end else begin
              r_dz    <= 1'b0;
              r_acc   <= {{WIDTH{1'b0}}, w_abs_a};
              r_state <= S_RUN;
            end
          end
        end
        S_RUN: begin
          r_acc <= w_step;
          r_cnt <= r_cnt + CNT_W'(1);
          if (w_last) begin
            r_state <= S_FIX;
          end
        end
        S_FIX: begin
          Hi      <= w_fix_hi;
          Lo      <= w_fix_lo;
          DZ      <= r_dz;
          done    <= 1'b1;
          busy    <= 1'b0;
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seq_mul_div.sv
module tb_seq_mul_div;

  localparam logic [1:0] OP_MULU = 2'b00;
  localparam logic [1:0] OP_MULS = 2'b01;
  localparam logic [1:0] OP_DIVU = 2'b10;
  localparam logic [1:0] OP_DIVS = 2'b11;

  logic        clk;
  logic        rst;
  logic        start;
  logic [1:0]  op;
  logic [31:0] A;
  logic [31:0] B;
  logic        busy;
  logic        done;
  logic [31:0] Hi;
  logic [31:0] Lo;
  logic        DZ;

  typedef struct {
    int          id;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dz;
  } exp_t;

  exp_t sb[$];

  int checks = 0;
  int errors = 0;
  logic [31:0] prev_hi = '0;
  logic [31:0] prev_lo = '0;
  logic [31:0] pend_hi = '0;
  logic [31:0] pend_lo = '0;
  int cur_id = 0;

  seq_mul_div #(.WIDTH(32), .CNT_W(6)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .op    (op),
    .A     (A),
    .B     (B),
    .busy  (busy),
    .done  (done),
    .Hi    (Hi),
    .Lo    (Lo),
    .DZ    (DZ)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Monitor: every done pulse is matched against the oldest expectation.
  initial begin
    forever begin
      @(negedge clk);
      if (!rst && done) begin
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL unexpected_done: Hi=%h Lo=%h DZ=%0b with no pending operation", Hi, Lo, DZ);
        end else begin
          exp_t e;
          e = sb.pop_front();
          if (Hi !== e.hi || Lo !== e.lo || DZ !== e.dz) begin
            errors++;
            $display("FAIL result_op%0d: got Hi=%h Lo=%h DZ=%0b, want Hi=%h Lo=%h DZ=%0b",
                     e.id, Hi, Lo, DZ, e.hi, e.lo, e.dz);
          end
        end
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
    $fatal(1, "watchdog");
  end

  // Drive a request (caller positions us in a cycle where busy=0) and queue
  // the expected result.
  task automatic issue(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] hi, input logic [31:0] lo, input logic dz);
    exp_t e;
    cur_id++;
    e.id = cur_id; e.hi = hi; e.lo = lo; e.dz = dz;
    sb.push_back(e);
    pend_hi = hi;
    pend_lo = lo;
    start = 1'b1;
    op = o;
    A = a;
    B = b;
  endtask

  // Entered #1 after the accepting edge. Returns #1 after the edge that
  // raised done (i.e. inside the done cycle).
  task automatic wait_done(input int lat, input bit poke);
    int  n = 0;
    int  bcnt = 0;
    bit  held = 1'b1;
    while (!done && n < 100) begin
      if (busy) bcnt++;
      if (Hi !== prev_hi || Lo !== prev_lo) held = 1'b0;
      if (poke && n == 5) begin
        start = 1'b1; op = OP_MULU; A = 32'd1; B = 32'd1;
      end
      if (poke && n == 6) start = 1'b0;
      @(posedge clk); #1;
      n++;
    end
    checks++;
    if (!done || busy || n != lat) begin
      errors++;
      $display("FAIL latency_op%0d: done=%0b busy=%0b after %0d edges, want done=1 busy=0 after %0d",
               cur_id, done, busy, n, lat);
    end
    checks++;
    if (bcnt != lat) begin
      errors++;
      $display("FAIL busy_len_op%0d: busy high %0d cycles, want %0d", cur_id, bcnt, lat);
    end
    checks++;
    if (!held) begin
      errors++;
      $display("FAIL hold_op%0d: Hi/Lo moved before done, want Hi=%h Lo=%h held", cur_id, prev_hi, prev_lo);
    end
    prev_hi = pend_hi;
    prev_lo = pend_lo;
  endtask

  task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] hi, input logic [31:0] lo, input logic dz,
                        input int lat, input bit poke);
    @(negedge clk);
    issue(o, a, b, hi, lo, dz);
    @(posedge clk); #1;
    start = 1'b0;
    A = $urandom;
    B = $urandom;
    wait_done(lat, poke);
  endtask

  initial begin
    int dcount;
    rst = 1'b1;
    start = 1'b0;
    op = 2'b00;
    A = '0;
    B = '0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || Hi !== 32'h0 || Lo !== 32'h0 || DZ !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: busy=%0b done=%0b Hi=%h Lo=%h DZ=%0b, want all zero", busy, done, Hi, Lo, DZ);
    end
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || Hi !== 32'h0 || Lo !== 32'h0) begin
      errors++;
      $display("FAIL idle_state: busy=%0b done=%0b Hi=%h Lo=%h, want 0 0 0 0", busy, done, Hi, Lo);
    end

    run_op(OP_MULU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0, 33, 1'b0);
    run_op(OP_MULS, 32'hFFFFFFFD, 32'h00000007, 32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0, 33, 1'b0);
    run_op(OP_MULU, 32'hFFFFFFFD, 32'h00000007, 32'h00000006, 32'hFFFFFFEB, 1'b0, 33, 1'b0);
    run_op(OP_DIVS, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0, 33, 1'b0);
    run_op(OP_DIVU, 32'd100,      32'd7,        32'd2,        32'd14,       1'b0, 33, 1'b1);
    run_op(OP_DIVS, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 1'b0, 33, 1'b0);
    run_op(OP_DIVU, 32'h00001234, 32'h00000000, 32'h00001234, 32'hFFFFFFFF, 1'b1, 1,  1'b0);
    run_op(OP_MULU, 32'd3,        32'd4,        32'd0,        32'd12,       1'b0, 33, 1'b0);

    // Back-to-back: a new start issued inside the done cycle.
    run_op(OP_DIVS, 32'd7, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 1'b0, 33, 1'b0);
    issue(OP_MULU, 32'd5, 32'd6, 32'd0, 32'd30, 1'b0);
    @(posedge clk); #1;
    start = 1'b0;
    A = 32'hDEADBEEF;
    B = 32'h0BADF00D;
    checks++;
    if (busy !== 1'b1 || done !== 1'b0) begin
      errors++;
      $display("FAIL accept_in_done: busy=%0b done=%0b, want busy=1 done=0", busy, done);
    end
    wait_done(33, 1'b0);

    run_op(OP_MULS, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 1'b0, 33, 1'b0);
    run_op(OP_DIVU, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 32'hFFFFFFFF, 1'b0, 33, 1'b0);
    run_op(OP_DIVS, 32'hFFFFFFF9, 32'h00000000, 32'hFFFFFFF9, 32'hFFFFFFFF, 1'b1, 1,  1'b0);
    run_op(OP_DIVU, 32'd5,        32'd7,        32'd5,        32'd0,        1'b0, 33, 1'b0);

    // Reset in the middle of RUN: no result may ever appear for it.
    @(negedge clk);
    start = 1'b1; op = OP_MULU; A = 32'd9; B = 32'd9;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || Hi !== 32'h0 || Lo !== 32'h0 || DZ !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_run: busy=%0b done=%0b Hi=%h Lo=%h DZ=%0b, want all zero", busy, done, Hi, Lo, DZ);
    end
    prev_hi = '0;
    prev_lo = '0;
    @(negedge clk);
    rst = 1'b0;
    dcount = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done || busy) dcount++;
    end
    checks++;
    if (dcount != 0) begin
      errors++;
      $display("FAIL no_done_after_reset: %0d busy/done cycles seen, want 0", dcount);
    end

    run_op(OP_MULU, 32'd3, 32'd4, 32'd0, 32'd12, 1'b0, 33, 1'b0);

    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d results outstanding, want 0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
